// File: rtl/probe_conditioner.sv
// Per-channel probe conditioning: synchroniser, edge/level event detect and
// retriggerable pulse stretcher, all advancing only on clock-gate-enabled edges.
module probe_conditioner #(
    parameter int N_PROBE     = 4,
    parameter int SYNC_STAGES = 2,  // legal range 2..4
    parameter int STRETCH_EXP = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic [N_PROBE-1:0]     i_probe,
    input  logic [N_PROBE-1:0]     i_mask,
    input  logic [1:0]             i_mode,
    input  logic [STRETCH_EXP-1:0] i_stretchLength,
    output logic [N_PROBE-1:0]     o_probe
);

    localparam logic [STRETCH_EXP-1:0] CNT_ZERO = '0;
    localparam logic [STRETCH_EXP-1:0] CNT_ONE  = {{(STRETCH_EXP-1){1'b0}}, 1'b1};

    // Mode decode is shared by every channel; 11 enables both edge detectors.
    logic level_mode;
    logic rise_en;
    logic fall_en;

    always_comb begin
        level_mode = (i_mode == 2'b00);
        rise_en    = i_mode[0];
        fall_en    = i_mode[1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_PROBE; gi = gi + 1) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic [STRETCH_EXP-1:0] cnt_reg;
            logic [STRETCH_EXP-1:0] cnt_next;
            logic                   out_reg;
            logic                   out_next;
            logic                   s_cur;
            logic                   ev;

            assign s_cur = sync_reg[SYNC_STAGES-1];

            always_comb begin
                if (level_mode) begin
                    ev = s_cur;
                end else begin
                    ev = (rise_en & s_cur & ~prev_reg) | (fall_en & ~s_cur & prev_reg);
                end
            end

            // Mask beats a fresh event, which beats the running stretch.
            always_comb begin
                cnt_next = cnt_reg;
                out_next = 1'b0;
                if (i_mask[gi]) begin
                    cnt_next = CNT_ZERO;
                    out_next = 1'b0;
                end else if (ev) begin
                    cnt_next = i_stretchLength;
                    out_next = 1'b1;
                end else if (cnt_reg != CNT_ZERO) begin
                    cnt_next = cnt_reg - CNT_ONE;
                    out_next = 1'b1;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                    cnt_reg  <= CNT_ZERO;
                    out_reg  <= 1'b0;
                end else if (i_cg) begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_probe[gi]};
                    prev_reg <= s_cur;
                    cnt_reg  <= cnt_next;
                    out_reg  <= out_next;
                end
            end

            assign o_probe[gi] = out_reg;
        end
    endgenerate

endmodule

// File: tb/tb_probe_conditioner.sv
// Directed scenario tasks plus a long randomized run against a queue/integer
// reference model of the probe conditioner.
module tb_probe_conditioner;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int SE = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cg;
    logic [N-1:0]  i_probe;
    logic [N-1:0]  i_mask;
    logic [1:0]    i_mode;
    logic [SE-1:0] i_stretchLength;
    logic [N-1:0]  o_probe;

    int checks = 0;
    int errors = 0;

    probe_conditioner #(.N_PROBE(N), .SYNC_STAGES(SS), .STRETCH_EXP(SE)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cg(i_cg),
        .i_probe(i_probe),
        .i_mask(i_mask),
        .i_mode(i_mode),
        .i_stretchLength(i_stretchLength),
        .o_probe(o_probe)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: pin history per channel, previous synced value,
    // remaining stretch cycles as a plain integer.
    bit m_hist [N][SS];
    bit m_p    [N];
    int m_cnt  [N];
    bit m_o    [N];

    task automatic model_step();
        bit s;
        bit ev;
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < SS; k++) m_hist[i][k] = 0;
                m_p[i] = 0;
                m_cnt[i] = 0;
                m_o[i] = 0;
            end
        end else if (i_cg) begin
            for (int i = 0; i < N; i++) begin
                s = m_hist[i][SS-1];
                case (i_mode)
                    2'd0: ev = s;
                    2'd1: ev = s && !m_p[i];
                    2'd2: ev = !s && m_p[i];
                    default: ev = s != m_p[i];
                endcase
                if (i_mask[i]) begin
                    m_cnt[i] = 0;
                    m_o[i] = 0;
                end else if (ev) begin
                    m_cnt[i] = int'(i_stretchLength);
                    m_o[i] = 1;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    m_o[i] = 1;
                end else begin
                    m_o[i] = 0;
                end
                m_p[i] = s;
                for (int k = SS - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = i_probe[i];
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    // Capture buffers for the directed scenarios (index = tick number).
    logic [N-1:0] cap    [64];
    bit           cap_cg [64];

    function automatic int first_high(input int ch, input int from, input int n);
        for (int t = from; t <= n; t++) if (cap[t][ch]) return t;
        return 0;
    endfunction

    function automatic int last_high(input int ch, input int n);
        int l = 0;
        for (int t = 1; t <= n; t++) if (cap[t][ch]) l = t;
        return l;
    endfunction

    function automatic int count_high(input int ch, input int n, input bit cg_only);
        int c = 0;
        for (int t = 1; t <= n; t++) if (cap[t][ch] && (!cg_only || cap_cg[t])) c++;
        return c;
    endfunction

    task automatic idle(input int n);
        i_probe = '0;
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_cg = 1'b1; i_probe = '0; i_mask = '0;
        i_mode = 2'b01; i_stretchLength = 4'd3;
        tick(); tick();
        i_rst = 1'b0;
        checks++;
        if (o_probe !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: o_probe=%b expected 0000", o_probe);
        end
        $display("test_reset: o_probe=%b", o_probe);
    endtask

    task automatic test_single_pulse();
        int f, c, l;
        bit other;
        idle(4);
        i_mode = 2'b01; i_stretchLength = 4'd3;
        for (int t = 1; t <= 12; t++) begin
            i_probe = {3'b000, t == 1};
            tick();
            cap[t] = o_probe;
        end
        f = first_high(0, 1, 12); c = count_high(0, 12, 0); l = last_high(0, 12);
        other = 0;
        for (int t = 1; t <= 12; t++) if (cap[t][3:1] != 3'b000) other = 1;
        checks++;
        if (f !== 3) begin errors++; $display("FAIL single_latency: first high tick %0d expected 3", f); end
        checks++;
        if (c !== 4) begin errors++; $display("FAIL single_length: high cycles %0d expected 4", c); end
        checks++;
        if (l - f + 1 !== c) begin errors++; $display("FAIL single_contig: span %0d high %0d", l - f + 1, c); end
        checks++;
        if (other !== 1'b0) begin errors++; $display("FAIL single_other: other channels went high, got %0d expected 0", other); end
        $display("test_single_pulse: first=%0d high=%0d", f, c);
    endtask

    task automatic test_retrigger();
        int f, c, l;
        idle(12);
        i_mode = 2'b01; i_stretchLength = 4'd5;
        for (int t = 1; t <= 20; t++) begin
            i_probe = {3'b000, (t == 1) || (t == 4)};
            tick();
            cap[t] = o_probe;
        end
        f = first_high(0, 1, 20); c = count_high(0, 20, 0); l = last_high(0, 20);
        checks++;
        if (f !== 3) begin errors++; $display("FAIL retrig_latency: first %0d expected 3", f); end
        checks++;
        if (c !== 9) begin errors++; $display("FAIL retrig_length: high %0d expected 9", c); end
        checks++;
        if (l - f + 1 !== c) begin errors++; $display("FAIL retrig_glitch: span %0d high %0d", l - f + 1, c); end
        $display("test_retrigger: first=%0d high=%0d", f, c);
    endtask

    task automatic test_level_and_fall();
        int f, c;
        idle(12);
        i_mode = 2'b00; i_stretchLength = 4'd2;
        for (int t = 1; t <= 25; t++) begin
            i_probe = {3'b000, t <= 10};
            tick();
            cap[t] = o_probe;
        end
        f = first_high(0, 1, 25); c = count_high(0, 25, 0);
        checks++;
        if (f !== 3) begin errors++; $display("FAIL level_latency: first %0d expected 3", f); end
        checks++;
        if (c !== 12) begin errors++; $display("FAIL level_length: high %0d expected 12", c); end
        $display("test_level: first=%0d high=%0d", f, c);
        i_mode = 2'b10;
        idle(8);
        for (int t = 1; t <= 25; t++) begin
            i_probe = {3'b000, t <= 10};
            tick();
            cap[t] = o_probe;
        end
        f = first_high(0, 1, 25); c = count_high(0, 25, 0);
        checks++;
        if (f !== 13) begin errors++; $display("FAIL fall_latency: first %0d expected 13", f); end
        checks++;
        if (c !== 3) begin errors++; $display("FAIL fall_length: high %0d expected 3", c); end
        $display("test_fall: first=%0d high=%0d", f, c);
    endtask

    task automatic test_clock_gate();
        int c;
        bit frozen_ok, ch2_seen;
        idle(12);
        i_mode = 2'b01; i_stretchLength = 4'd7;
        frozen_ok = 1; ch2_seen = 0;
        for (int t = 1; t <= 25; t++) begin
            i_cg = !(t >= 6 && t <= 10);
            i_probe = {1'b0, t == 8, 1'b0, t == 1};
            tick();
            cap[t] = o_probe; cap_cg[t] = i_cg;
            if (!i_cg && o_probe[0] !== 1'b1) frozen_ok = 0;
            if (o_probe[2]) ch2_seen = 1;
        end
        i_cg = 1'b1;
        for (int t = 0; t < 6; t++) begin
            i_probe = '0; tick();
            if (o_probe[2]) ch2_seen = 1;
        end
        c = count_high(0, 25, 1);
        checks++;
        if (c !== 8) begin errors++; $display("FAIL cg_length: cg-high cycles high %0d expected 8", c); end
        checks++;
        if (frozen_ok !== 1'b1) begin errors++; $display("FAIL cg_freeze: held=%0d expected 1", frozen_ok); end
        checks++;
        if (ch2_seen !== 1'b0) begin errors++; $display("FAIL cg_hidden_pulse: ch2 seen=%0d expected 0", ch2_seen); end
        $display("test_clock_gate: high=%0d frozen_ok=%0d", c, frozen_ok);
    endtask

    task automatic test_mask_and_reset_hold();
        int c, f, l;
        bit masked_clean;
        idle(12);
        i_mode = 2'b01; i_stretchLength = 4'd7;
        masked_clean = 1;
        for (int t = 1; t <= 30; t++) begin
            i_probe = {2'b00, (t == 1) || (t == 21), 1'b0};
            i_mask  = {2'b00, t == 6, 1'b0};
            tick();
            cap[t] = o_probe;
            if (t >= 6 && t < 21 && o_probe[1]) masked_clean = 0;
        end
        i_mask = '0;
        f = first_high(1, 6, 30);
        checks++;
        if (masked_clean !== 1'b1) begin errors++; $display("FAIL mask_clear: clean=%0d expected 1", masked_clean); end
        checks++;
        if (f !== 23) begin errors++; $display("FAIL mask_new_event: first %0d expected 23", f); end
        $display("test_mask: clean=%0d retrigger_at=%0d", masked_clean, f);
        // Pin held high through reset release must give exactly one pulse.
        i_stretchLength = 4'd2;
        i_probe = 4'b1000;
        i_rst = 1'b1;
        tick(); tick(); tick();
        i_rst = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            cap[t] = o_probe;
        end
        c = count_high(3, 20, 0); f = first_high(3, 1, 20); l = last_high(3, 20);
        checks++;
        if (c !== 3 || l - f + 1 !== 3) begin
            errors++;
            $display("FAIL reset_hold: high %0d span %0d expected 3 and 3", c, l - f + 1);
        end
        $display("test_reset_hold: high=%0d", c);
        idle(4);
    endtask

    task automatic test_random();
        int bad = 0;
        logic [N-1:0] exp_o;
        for (int t = 0; t < 20000; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) i_probe[i] = ~i_probe[i];
            if ($urandom_range(0, 49) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) i_stretchLength = SE'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) i_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            i_rst = ($urandom_range(0, 1999) == 0);
            i_cg  = i_rst || ($urandom_range(0, 9) != 0);
            tick();
            for (int i = 0; i < N; i++) exp_o[i] = m_o[i];
            checks++;
            if (o_probe !== exp_o) begin
                errors++; bad++;
                if (bad <= 20) $display("FAIL random_cycle %0d: o_probe=%b expected %b", t, o_probe, exp_o);
            end
        end
        i_rst = 1'b0; i_cg = 1'b1; i_mask = '0;
        $display("test_random: 20000 cycles, mismatches=%0d", bad);
    endtask

    initial begin
        i_rst = 1'b1; i_cg = 1'b1; i_probe = '0; i_mask = '0;
        i_mode = 2'b01; i_stretchLength = '0;
        test_reset();
        test_single_pulse();
        test_retrigger();
        test_level_and_fall();
        test_clock_gate();
        test_mask_and_reset_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
